// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the packed-data lane offset helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Bit offset of requester idx inside a packed {req N-1, ..., req 0} data bus.
    function automatic int unsigned data_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority picker: returns the first set request at or after rr_ptr,
// wrapping explicitly so NUM_REQ need not be a power of two.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               any,
    output logic [IW-1:0]      pick
);

    always_comb begin
        int idx;
        any  = |req;
        pick = '0;
        idx  = 0;
        // Walk offsets from far to near so the nearest set request wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                pick = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers.
// A grant lasts until the owner's last word or MAX_BURST words, then rotates.
//
// Handshake: a word moves when req_valid[i] & req_ready[i] are both high on a
// wclk edge; req_ready is only ever high for the current owner while the FIFO
// is not full, and that same condition drives fifo_w_en combinationally.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int Width     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       wclk,
    input  logic                       wrst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*Width-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_w_en,
    output logic [Width-1:0]           fifo_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IW-1:0]    rr_ptr;
    logic [BW-1:0]    burst_cnt;
    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic             owner_valid;
    logic             owner_last;
    logic [Width-1:0] owner_data;
    logic             transfer;
    logic             done;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .pick   (pick_idx)
    );

    // Owner mux written as a compare loop so out-of-range indices select nothing.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IW'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[data_lsb(i, Width) +: Width];
            end
        end
    end

    assign busy      = (state == GRANT);
    assign transfer  = busy & owner_valid & ~fifo_full;
    assign done      = transfer & (owner_last | (burst_cnt == BURST_END));
    assign fifo_w_en = transfer;
    assign fifo_data = transfer ? owner_data : '0;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (busy && !fifo_full && (grant_id == IW'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any) state_next = GRANT;
            GRANT:   if (done)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                grant_id  <= pick_idx;
                burst_cnt <= '0;
            end
            // Counter returns to zero on release so it never reaches MAX_BURST.
            if (transfer) begin
                burst_cnt <= done ? '0 : burst_cnt + BW'(1);
            end
            if (done) begin
                rr_ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + IW'(1);
            end
        end
    end

endmodule
